// File: rtl/relay_pkg.sv
// ---------------------------------------------------------------------------
// relay_pkg
// Shared types and defaults for the G-15 relay power sequencer.
//   relay_seq_state_t     : sequencer FSM states
//   RELAY_*_MS_DEF        : default timing constants, in 1 ms ticks
//   relay_cnt_width()     : width of a saturating tick counter that must
//                           hold the largest of three tick limits
// ---------------------------------------------------------------------------
package relay_pkg;

  typedef enum logic [2:0] {
    IDLE_DN,
    UP_WAIT,
    UP_SETTLE,
    READY,
    DN_WAIT,
    DN_SETTLE,
    FAULT
  } relay_seq_state_t;

  localparam int RELAY_TIMEOUT_MS_DEF  = 20;
  localparam int RELAY_SETTLE_MS_DEF   = 5;
  localparam int RELAY_DEBOUNCE_MS_DEF = 2;

  // Never returns less than 1 so a counter vector is always legal.
  function automatic int relay_cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/relay_seq_if.sv
// ---------------------------------------------------------------------------
// relay_seq_if
// Control-panel / relay-bank bundle for relay_seq.
//   tick_ms, start, stop, fault_clr : control-panel and timer inputs
//   pulled[N_RELAYS]                : contact status from the relays
//   pick[N_RELAYS]                  : pick drive to the relays
//   busy, ready, fault, step        : sequencer status
// Modports:
//   master : the panel / relay side (drives requests and contact status)
//   slave  : the sequencer side
// ---------------------------------------------------------------------------
interface relay_seq_if #(
  parameter int N_RELAYS = 4
) ();

  localparam int STEP_W = $clog2(N_RELAYS) + 1;

  logic                tick_ms;
  logic                start;
  logic                stop;
  logic                fault_clr;
  logic [N_RELAYS-1:0] pulled;
  logic [N_RELAYS-1:0] pick;
  logic                busy;
  logic                ready;
  logic                fault;
  logic [STEP_W-1:0]   step;

  modport master (
    output tick_ms, start, stop, fault_clr, pulled,
    input  pick, busy, ready, fault, step
  );

  modport slave (
    input  tick_ms, start, stop, fault_clr, pulled,
    output pick, busy, ready, fault, step
  );

endinterface

// File: rtl/relay_debounce.sv
// ---------------------------------------------------------------------------
// relay_debounce
// Synchronises one relay contact bit into the clk domain and filters it:
// the output q only follows the synchronised input after that input has
// differed from q for DEBOUNCE_MS consecutive tick_ms pulses.
//   clk, rst : clock, asynchronous active-high reset (q resets to 0)
//   tick_ms  : 1 ms tick
//   d        : raw contact bit
//   q        : synchronised, debounced contact bit
// ---------------------------------------------------------------------------
module relay_debounce
  import relay_pkg::*;
#(
  parameter int DEBOUNCE_MS = RELAY_DEBOUNCE_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic d,
  output logic q
);

  localparam int CNT_W = relay_cnt_width(DEBOUNCE_MS, 1, 1);
  localparam logic [CNT_W:0] DEB_LIM = (CNT_W + 1)'(DEBOUNCE_MS);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_plus;

  assign cnt_plus = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  // Any return to the current filtered value restarts the stability count,
  // so a glitch shorter than DEBOUNCE_MS ticks never reaches q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      if (sync_q == q) begin
        cnt_q <= '0;
      end else if (tick_ms) begin
        if (cnt_plus >= DEB_LIM) begin
          q     <= sync_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_plus[CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/relay_seq.sv
// ---------------------------------------------------------------------------
// relay_seq
// Power-up / power-down sequencer for a bank of G-15 relays. Relays are
// picked in ascending order on start and dropped in descending order on
// stop; each transition must be confirmed on pulled within TIMEOUT_MS
// ticks and is followed by SETTLE_MS ticks before the next step. Timeouts
// and unexpected drops while READY latch a fault that forces all picks off
// until fault_clr.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : relay_seq_if.slave (tick_ms, start, stop, fault_clr, pulled in;
//          pick, busy, ready, fault, step out; all outputs registered)
// Build option:
//   RELAY_SEQ_DEBOUNCE_EN : when defined, each pulled bit passes through a
//          2-flop synchroniser and a DEBOUNCE_MS-tick debouncer before use;
//          otherwise pulled is used raw (already synchronous to clk).
// ---------------------------------------------------------------------------
module relay_seq
  import relay_pkg::*;
#(
  parameter int N_RELAYS    = 4,
  parameter int TIMEOUT_MS  = RELAY_TIMEOUT_MS_DEF,
  parameter int SETTLE_MS   = RELAY_SETTLE_MS_DEF,
  parameter int DEBOUNCE_MS = RELAY_DEBOUNCE_MS_DEF
) (
  input logic         clk,
  input logic         rst,
  relay_seq_if.slave  bus
);

  localparam int STEP_W = $clog2(N_RELAYS) + 1;
  localparam int CNT_W  = relay_cnt_width(TIMEOUT_MS, SETTLE_MS, DEBOUNCE_MS);

  localparam logic [CNT_W:0]        TIMEOUT_LIM = (CNT_W + 1)'(TIMEOUT_MS);
  localparam logic [CNT_W:0]        SETTLE_LIM  = (CNT_W + 1)'(SETTLE_MS);
  localparam logic [STEP_W-1:0]     LAST_STEP   = STEP_W'(N_RELAYS - 1);
  localparam logic [N_RELAYS-1:0]   LAST_MASK   = N_RELAYS'(1) << (N_RELAYS - 1);

  relay_seq_state_t    state_q, state_d;
  logic [N_RELAYS-1:0] pick_q, pick_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                fault_q, fault_d;

  logic [N_RELAYS-1:0] pulled_f;
  logic [N_RELAYS-1:0] cur_mask;
  logic                cur_pulled;
  logic [CNT_W:0]      cnt_plus;
  logic [CNT_W-1:0]    cnt_sat;
  logic                timeout_hit;
  logic                settle_hit;

`ifdef RELAY_SEQ_DEBOUNCE_EN
  for (genvar i = 0; i < N_RELAYS; i++) begin : g_deb
    relay_debounce #(
      .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .tick_ms (bus.tick_ms),
      .d       (bus.pulled[i]),
      .q       (pulled_f[i])
    );
  end
`else
  assign pulled_f = bus.pulled;
`endif

  // One-hot mask of the relay being handled; avoids indexing pulled with a
  // step value that is one bit wider than the relay index.
  assign cur_mask   = N_RELAYS'(1) << step_q;
  assign cur_pulled = |(pulled_f & cur_mask);

  // The tick that would take the count to the limit is the one that fires,
  // so a limit of L means the L-th tick seen in the state.
  assign cnt_plus    = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign cnt_sat     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_plus >= TIMEOUT_LIM);
  assign settle_hit  = (cnt_plus >= SETTLE_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_DN;
      pick_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pick_q  <= pick_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic. Status flags are derived from the next state so they
  // are registered alongside it and never lag the pick drive.
  always_comb begin
    state_d = state_q;
    pick_d  = pick_q;
    step_d  = step_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE_DN: begin
        if (bus.start && !bus.stop && !fault_q) begin
          pick_d  = N_RELAYS'(1);
          step_d  = '0;
          cnt_d   = '0;
          state_d = UP_WAIT;
        end
      end

      UP_WAIT: begin
        if (bus.stop) begin
          // Abort: release the relay in flight and unwind from here.
          pick_d  = pick_q & ~cur_mask;
          cnt_d   = '0;
          state_d = DN_WAIT;
        end else if (cur_pulled) begin
          cnt_d   = '0;
          state_d = UP_SETTLE;
        end else if (bus.tick_ms) begin
          if (timeout_hit) begin
            pick_d  = '0;
            state_d = FAULT;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end

      UP_SETTLE: begin
        if (bus.stop) begin
          pick_d  = pick_q & ~cur_mask;
          cnt_d   = '0;
          state_d = DN_WAIT;
        end else if (bus.tick_ms) begin
          if (settle_hit) begin
            cnt_d = '0;
            if (step_q == LAST_STEP) begin
              state_d = READY;
            end else begin
              step_d  = step_q + STEP_W'(1);
              pick_d  = pick_q | (cur_mask << 1);
              state_d = UP_WAIT;
            end
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end

      READY: begin
        if (!(&pulled_f)) begin
          pick_d  = '0;
          state_d = FAULT;
        end else if (bus.stop) begin
          step_d  = LAST_STEP;
          pick_d  = pick_q & ~LAST_MASK;
          cnt_d   = '0;
          state_d = DN_WAIT;
        end
      end

      DN_WAIT: begin
        if (!cur_pulled) begin
          cnt_d   = '0;
          state_d = DN_SETTLE;
        end else if (bus.tick_ms) begin
          if (timeout_hit) begin
            pick_d  = '0;
            state_d = FAULT;
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end

      DN_SETTLE: begin
        if (bus.tick_ms) begin
          if (settle_hit) begin
            cnt_d = '0;
            if (step_q == '0) begin
              state_d = IDLE_DN;
            end else begin
              step_d  = step_q - STEP_W'(1);
              pick_d  = pick_q & ~(cur_mask >> 1);
              state_d = DN_WAIT;
            end
          end else begin
            cnt_d = cnt_sat;
          end
        end
      end

      FAULT: begin
        pick_d = '0;
        if (bus.fault_clr) begin
          step_d  = '0;
          cnt_d   = '0;
          state_d = IDLE_DN;
        end
      end

      default: begin
        pick_d  = '0;
        step_d  = '0;
        cnt_d   = '0;
        state_d = IDLE_DN;
      end
    endcase

    busy_d  = (state_d == UP_WAIT) || (state_d == UP_SETTLE) ||
              (state_d == DN_WAIT) || (state_d == DN_SETTLE);
    ready_d = (state_d == READY);
    fault_d = (state_d == FAULT);
  end

  assign bus.pick  = pick_q;
  assign bus.step  = step_q;
  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_relay_seq.sv
// ---------------------------------------------------------------------------
// tb_relay_seq
// Self-checking bench for relay_seq (default build, debounce disabled).
// Relay stubs follow each pick edge after a per-relay delay; a behavioural
// model of the sequencing rules predicts pick/step/busy/ready/fault every
// cycle. Directed scenarios are followed by randomized requests and delays.
// ---------------------------------------------------------------------------
module tb_relay_seq;

  localparam int N        = 4;
  localparam int TMO      = 20;
  localparam int STL      = 5;
  localparam int TICK_DIV = 10;

  localparam int PH_IDLE    = 0;
  localparam int PH_CONFIRM = 1;
  localparam int PH_SETTLE  = 2;
  localparam int PH_READY   = 3;
  localparam int PH_FAULT   = 4;

  logic clk = 1'b0;
  logic rst;

  relay_seq_if #(.N_RELAYS(N)) bus ();

  relay_seq #(
    .N_RELAYS    (N),
    .TIMEOUT_MS  (TMO),
    .SETTLE_MS   (STL),
    .DEBOUNCE_MS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Relay stubs
  int           dly   [N];
  bit           stuck [N];
  int           timer [N];
  logic [N-1:0] stub_pick;
  logic [N-1:0] stub_out;

  // Reference model: the bank is a thermometer of m_on picked relays,
  // m_up gives the direction, m_idx the relay being confirmed or settled.
  int m_phase;
  int m_idx;
  int m_on;
  int m_ticks;
  bit m_up;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] therm(input int k);
    logic [31:0] t;
    t = (32'd1 << k) - 32'd1;
    return t[N-1:0];
  endfunction

  task automatic modelStep();
    if (rst) begin
      m_phase = PH_IDLE; m_idx = 0; m_on = 0; m_ticks = 0; m_up = 0;
      return;
    end
    case (m_phase)
      PH_IDLE: begin
        if (bus.start && !bus.stop) begin
          m_up = 1; m_idx = 0; m_on = 1; m_ticks = 0; m_phase = PH_CONFIRM;
        end
      end
      PH_CONFIRM: begin
        if (m_up && bus.stop) begin
          m_up = 0; m_on = m_idx; m_ticks = 0; m_phase = PH_CONFIRM;
        end else if (bus.pulled[m_idx] == m_up) begin
          m_ticks = 0; m_phase = PH_SETTLE;
        end else if (bus.tick_ms) begin
          m_ticks++;
          if (m_ticks == TMO) begin
            m_phase = PH_FAULT; m_on = 0;
          end
        end
      end
      PH_SETTLE: begin
        if (m_up && bus.stop) begin
          m_up = 0; m_on = m_idx; m_ticks = 0; m_phase = PH_CONFIRM;
        end else if (bus.tick_ms) begin
          m_ticks++;
          if (m_ticks == STL) begin
            m_ticks = 0;
            if (m_up) begin
              if (m_idx == N - 1) m_phase = PH_READY;
              else begin m_idx++; m_on++; m_phase = PH_CONFIRM; end
            end else begin
              if (m_idx == 0) m_phase = PH_IDLE;
              else begin m_idx--; m_on--; m_phase = PH_CONFIRM; end
            end
          end
        end
      end
      PH_READY: begin
        if (bus.pulled != {N{1'b1}}) begin
          m_phase = PH_FAULT; m_on = 0;
        end else if (bus.stop) begin
          m_up = 0; m_idx = N - 1; m_on = N - 1; m_ticks = 0; m_phase = PH_CONFIRM;
        end
      end
      default: begin
        if (bus.fault_clr) begin
          m_phase = PH_IDLE; m_idx = 0;
        end
      end
    endcase
  endtask

  task automatic checkAll();
    checkOutput("pick",  32'(bus.pick),  32'(therm(m_on)));
    checkOutput("step",  32'(bus.step),  32'(m_idx));
    checkOutput("busy",  32'(bus.busy),  32'(m_phase == PH_CONFIRM || m_phase == PH_SETTLE));
    checkOutput("ready", 32'(bus.ready), 32'(m_phase == PH_READY));
    checkOutput("fault", 32'(bus.fault), 32'(m_phase == PH_FAULT));
  endtask

  task automatic updateStubs();
    for (int i = 0; i < N; i++) begin
      if (bus.pick[i] !== stub_pick[i]) begin
        stub_pick[i] = bus.pick[i];
        timer[i]     = dly[i];
      end else if (timer[i] > 0) begin
        timer[i]--;
        if (timer[i] == 0) stub_out[i] = stuck[i] ? 1'b0 : stub_pick[i];
      end
    end
  endtask

  task automatic runCycle();
    @(posedge clk);
    modelStep();
    cyc++;
    @(negedge clk);
    checkAll();
    updateStubs();
    bus.tick_ms = ((cyc % TICK_DIV) == TICK_DIV - 1);
  endtask

  task automatic applyStimulus(input bit s, input bit p, input bit c, input logic [N-1:0] g);
    bus.start     = s;
    bus.stop      = p;
    bus.fault_clr = c;
    bus.pulled    = stub_out ^ g;
    runCycle();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0);
  endtask

  task automatic powerUp(input string tag);
    int n;
    applyStimulus(1, 0, 0, '0);
    n = 0;
    while (!bus.ready && n < 600) begin
      idleCycles(1);
      n++;
    end
    checkOutput(tag, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int n;
    int t0;
    int t1;
    bit seen2;

    rst = 1'b1;
    bus.tick_ms = 0; bus.start = 0; bus.stop = 0; bus.fault_clr = 0;
    stub_pick = '0; stub_out = '0; bus.pulled = '0;
    for (int i = 0; i < N; i++) begin dly[i] = 30; stuck[i] = 0; timer[i] = 0; end
    m_phase = PH_IDLE; m_idx = 0; m_on = 0; m_ticks = 0; m_up = 0;

    // Reset state
    idleCycles(3);
    rst = 1'b0;
    idleCycles(5);

    // 1: ascending power-up, latency from start to ready
    $display("[TB] power-up");
    t0 = cyc;
    powerUp("up_ready");
    t1 = cyc - t0;
    checkOutput("up_latency", 32'(t1 >= 280 && t1 <= 380), 32'd1);
    checkOutput("up_pick_all", 32'(bus.pick), 32'hF);

    // 2: descending power-down back to idle
    $display("[TB] power-down");
    applyStimulus(0, 1, 0, '0);
    checkOutput("dn_first_pick", 32'(bus.pick), 32'h7);
    n = 0;
    while (bus.busy && n < 600) begin idleCycles(1); n++; end
    checkOutput("dn_idle", {bus.busy, bus.ready, bus.fault, 4'(bus.pick), 3'(bus.step)}, '0);
    idleCycles(40);

    // 3: relay 2 never pulls -> timeout 20 ticks after its pick
    $display("[TB] timeout");
    stuck[2] = 1;
    applyStimulus(1, 0, 0, '0);
    n = 0;
    while (!bus.pick[2] && n < 600) begin idleCycles(1); n++; end
    t0 = cyc;
    n = 0;
    while (!bus.fault && n < 400) begin idleCycles(1); n++; end
    t1 = cyc - t0;
    checkOutput("timeout_delay", 32'(t1 >= 191 && t1 <= 200), 32'd1);
    checkOutput("timeout_pick", 32'(bus.pick), 32'h0);
    idleCycles(5);
    applyStimulus(1, 0, 1, '0);
    checkOutput("clr_ignores_start", {bus.fault, 4'(bus.pick)}, '0);
    stuck[2] = 0;
    idleCycles(40);
    applyStimulus(1, 0, 0, '0);
    checkOutput("restart_pick", 32'(bus.pick), 32'h1);
    n = 0;
    while (!bus.ready && n < 600) begin idleCycles(1); n++; end
    checkOutput("restart_ready", 32'(bus.ready), 32'd1);

    // 4: unexpected drop while ready
    $display("[TB] drop in ready");
    idleCycles(3);
    applyStimulus(0, 0, 0, 4'b0010);
    checkOutput("drop_fault", {bus.fault, bus.ready, 4'(bus.pick)}, 6'b100000);
    idleCycles(3);
    applyStimulus(0, 0, 1, '0);
    idleCycles(60);

    // 5: abort during settle of relay 1, then start+stop together
    $display("[TB] abort");
    applyStimulus(1, 0, 0, '0);
    n = 0;
    while (!(bus.step == 1 && stub_out[1]) && n < 600) begin idleCycles(1); n++; end
    idleCycles(3);
    applyStimulus(0, 1, 0, '0);
    checkOutput("abort_pick", 32'(bus.pick), 32'h1);
    seen2 = 0;
    n = 0;
    while (bus.busy && n < 600) begin
      idleCycles(1);
      if (bus.pick[2]) seen2 = 1;
      n++;
    end
    checkOutput("abort_no_pick2", 32'(seen2), 32'd0);
    checkOutput("abort_end_pick", 32'(bus.pick), 32'h0);
    idleCycles(40);
    applyStimulus(1, 1, 0, '0);
    checkOutput("start_stop_same", {bus.busy, 4'(bus.pick)}, '0);
    idleCycles(5);

    // 6: asynchronous reset in the middle of DN_WAIT
    $display("[TB] async reset");
    powerUp("rst_ready");
    applyStimulus(0, 1, 0, '0);
    idleCycles(5);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_flags", {bus.busy, bus.ready, bus.fault, 4'(bus.pick), 3'(bus.step)}, '0);
    idleCycles(2);
    rst = 1'b0;
    idleCycles(60);

    // Randomized requests, relay delays, stuck relays and glitches
    $display("[TB] random");
    for (int seg = 0; seg < 40; seg++) begin
      for (int i = 0; i < N; i++) begin
        dly[i]   = $urandom_range(5, 230);
        stuck[i] = (($urandom % 8) == 0);
      end
      for (int k = 0; k < 400; k++) begin
        applyStimulus(($urandom % 30) == 0,
                      ($urandom % 150) == 0,
                      ($urandom % 20) == 0,
                      (($urandom % 200) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
